mult_sched: RTL
===============

Name: mult_sched

Overview:
Two-requester scheduler and sequencer for the shared shift-add signed multiplier datapath: A/X accumulator, B multiplier shift register, and a 9-bit adder/subtractor.
- Arbitrates between two clients with round-robin priority.
- Drives the grant-controlled operand mux select.
- Sequences the datapath with a bit counter rather than unrolled states.
- Returns a one-cycle Done pulse to the winning client.
- Sits between the client logic and the multiplier datapath.

Parameters:
WIDTH, 8, operand width in bits; number of add/shift iterations; must be at least 2.

Ports:
Clk  in  1  system clock; all state updates on rising edge.
Reset_n  in  1  asynchronous, active-low reset.
Req  in  2  per-client request; level, held until that client's Done.
M  in  1  current LSB of datapath B register (multiplier bit).
Grant  out  2  one-hot owner of the datapath; 0 when idle.
Sel  out  1  operand mux select (0 = client 0, 1 = client 1); valid while Busy.
Load_Op  out  1  load selected operands into datapath S/B registers.
Clr_AX  out  1  clear A and X registers.
Add_En  out  1  latch adder result into A/X.
Sub  out  1  adder performs subtraction (sign bit of multiplier).
Shift_En  out  1  arithmetic right shift of X:A:B.
Busy  out  1  operation in progress.
Done  out  2  one-cycle pulse to the owning client on completion.

Behaviour:
Reset:
- Reset_n low forces, asynchronously: state IDLE, counter 0, Grant 0, Sel 0, all strobes 0, Busy 0, Done 0, last_grant 1.
- With last_grant 1, client 0 wins the first contest.

States (Moore outputs, registered state, combinational outputs):
- IDLE: all outputs 0.
  - Any Req set: choose a winner, register it in owner/Sel, go to LOAD.
  - Both Req set: winner is the client opposite last_grant.
  - Single Req set: that client wins.
- LOAD: Load_Op=1, Clr_AX=1, Busy=1. Counter cleared to 0. Go to ADD.
- ADD: Busy=1; Add_En=M.
  - Sub=M only when counter == WIDTH-1; otherwise Sub=0.
  - Go to SHIFT.
- SHIFT: Shift_En=1, Busy=1.
  - Counter == WIDTH-1: go to DONE.
  - Otherwise: increment counter and go to ADD.
- DONE: Busy=1; Done[owner]=1 for exactly this cycle; last_grant <= owner; go to IDLE.

Grant and Sel:
- Grant equals the one-hot owner in every state except IDLE.
- Sel and owner are stable from LOAD through DONE.

Latency:
- Req sampled high in IDLE at edge t gives LOAD at t+1 and Done at cycle t+2*WIDTH+2 (18 for WIDTH=8).
- Back-to-back operations have exactly one IDLE cycle between DONE and the next LOAD.

Boundary conditions:
- Req deasserted mid-operation: no abort; the sequence completes and Done still pulses.
- Owner's Req still high in the IDLE cycle after Done: treated as a new request, and round-robin applies.
  - Example: Req=11 continuously alternates owners 0,1,0,1.
- Req change while Busy: ignored until IDLE.
- Reset_n asserted mid-operation: immediate return to reset values; no Done is issued.
- Counter width is $clog2(WIDTH). The counter must not wrap before SHIFT at WIDTH-1.
- Only one of Load_Op, Add_En, Shift_En may be high in any cycle; the bench asserts this.

Decomposition:
- Package mult_pkg holds:
  - state enum (IDLE, LOAD, ADD, SHIFT, DONE);
  - WIDTH default constant;
  - client index type.
- Sub-module rr_arb2: combinational 2-way round-robin pick from Req and last_grant, producing a one-hot winner.
  - The last_grant register stays in mult_sched, updated in DONE.

Test Plan:
1. Reset then Req=01 at cycle 0.
   - Required: Grant=01 and Load_Op=Clr_AX=1 in cycle 1.
   - Required: 8 ADD/SHIFT pairs, then Done=01 at cycle 18; Busy low at cycle 19.
2. With the datapath model, client 0 operands 0x07 x 0xFB.
   - Required: Sub=1 only in the last ADD; product 0xFFDD (-35).
   - Required: client 1 operands 0x80 x 0x80 give 0x4000.
3. Req=11 held for three operations.
   - Required: owners 0,1,0; Done pulses 01,10,01.
   - Required: one IDLE cycle between each DONE and the next LOAD.
4. M=0 on all iterations.
   - Required: Add_En never high and Shift_En pulses exactly 8 times.
   - Required: with M=1 on all iterations, Add_En is high 8 times and Sub high once.
5. Req0 dropped at cycle 5 of an operation.
   - Required: sequence continues and Done=01 still occurs at cycle 18.
   - Required: Req1 raised at cycle 5 is granted only at the next IDLE.
6. Reset_n pulsed low at cycle 9 mid-operation.
   - Required: all outputs 0 asynchronously and no Done.
   - Required: after release, Req=11 grants client 0 first.

Source files
------------

// File: rtl/mult_pkg.sv
// Purpose : shared types for the shift-add multiplier scheduler.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mult_pkg;

    localparam int MULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Index of a requesting client: 0 or 1.
    typedef logic client_t;

    function automatic logic [1:0] client_onehot(input client_t c);
        return c ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mult_sched_rr_arb2.sv
// Purpose : combinational 2-way round-robin pick between two requesters.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; the caller samples win_o only when it can accept a winner.
// Ports   : req_i per-client requests, last_grant_i previous owner,
//           win_o one-hot winner (0 when no request).
module rr_arb2
    import mult_pkg::*;
(
    input  logic [1:0] req_i,
    input  client_t    last_grant_i,
    output logic [1:0] win_o
);

    always_comb begin
        win_o = 2'b00;
        case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            // Contention: the client that did not win last time goes first.
            2'b11:   win_o = last_grant_i ? 2'b01 : 2'b10;
            default: win_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mult_sched.sv
// Purpose : arbitrates two clients onto the shared shift-add signed multiplier
//           and sequences its datapath strobes with a bit counter.
// Latency : Req seen in IDLE at edge t -> LOAD at t+1, Done pulse at t+2*WIDTH+2.
// Backpressure: Req is a held level; changes while Busy are ignored until IDLE.
// Ports   : Clk/Reset_n clock and async active-low reset; Req client requests;
//           M multiplier LSB from datapath; Grant/Sel ownership and operand mux;
//           Load_Op/Clr_AX/Add_En/Sub/Shift_En datapath strobes; Busy; Done pulse.
module mult_sched
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [1:0] Req,
    input  logic       M,
    output logic [1:0] Grant,
    output logic       Sel,
    output logic       Load_Op,
    output logic       Clr_AX,
    output logic       Add_En,
    output logic       Sub,
    output logic       Shift_En,
    output logic       Busy,
    output logic [1:0] Done
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    client_t       sel_q, sel_d;
    client_t       last_q, last_d;
    logic [1:0]    win;

    rr_arb2 u_arb (
        .req_i        (Req),
        .last_grant_i (last_q),
        .win_o        (win)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            // Starting with last owner = 1 lets client 0 win the first contest.
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        last_d   = last_q;
        Load_Op  = 1'b0;
        Clr_AX   = 1'b0;
        Add_En   = 1'b0;
        Sub      = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 2'b00;

        case (state_q)
            IDLE: begin
                if (|Req) begin
                    sel_d   = win[1];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                Load_Op = 1'b1;
                Clr_AX  = 1'b1;
                Busy    = 1'b1;
                cnt_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                Busy    = 1'b1;
                Add_En  = M;
                // The top multiplier bit carries negative weight in two's complement.
                Sub     = M && (cnt_q == LAST);
                state_d = SHIFT;
            end
            SHIFT: begin
                Busy     = 1'b1;
                Shift_En = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ADD;
                end
            end
            DONE: begin
                Busy    = 1'b1;
                Done    = client_onehot(sel_q);
                last_d  = sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ownership is only visible while an operation is in flight.
    assign Grant = (state_q != IDLE) ? client_onehot(sel_q) : 2'b00;
    assign Sel   = (state_q != IDLE) && sel_q;

endmodule
